servant_grid_barrier: RTL

Generation scheduler for a grid of servant cells that exchange state through their nine-direction GPIO register banks (C, N, NE, E, SE, S, SW, W, NW).
- Each cell signals "published" by pulsing its GPIO out-clock.
- Once every cell has published for the current generation, the block waits a guard interval, then issues one broadcast latch pulse. All cells drive this pulse into their GPIO in-clock, so each cell copies its neighbour data into its own registers.
- The block also counts generations, enforces an optional generation limit, and flags timeouts and protocol overruns.

---
 rtl/servant_grid_pkg.sv | 52 +++++
 rtl/servant_barrier_timer.sv | 46 ++++
 rtl/servant_grid_barrier.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/servant_grid_pkg.sv
// servant_grid_pkg
// Shared definitions for the servant grid generation barrier:
//   - barrier FSM state encoding (S_IDLE .. S_FAULT)
//   - neighbour direction indices (DIR_C .. DIR_NW)
//   - GPIO register-bank word offsets, one word per direction
//   - timer_width(): width of the shared guard/timeout counter
package servant_grid_pkg;

  localparam int STATE_W = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_GUARD   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  // Neighbour directions of a cell's GPIO bank, centre first then clockwise.
  localparam int DIR_C    = 0;
  localparam int DIR_N    = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;
  localparam int NUM_DIRS = 9;

  // Word offsets of each direction's register inside a cell's GPIO bank.
  localparam int GPIO_WORD_C  = DIR_C;
  localparam int GPIO_WORD_N  = DIR_N;
  localparam int GPIO_WORD_NE = DIR_NE;
  localparam int GPIO_WORD_E  = DIR_E;
  localparam int GPIO_WORD_SE = DIR_SE;
  localparam int GPIO_WORD_S  = DIR_S;
  localparam int GPIO_WORD_SW = DIR_SW;
  localparam int GPIO_WORD_W  = DIR_W;
  localparam int GPIO_WORD_NW = DIR_NW;

  // Counter must hold the larger of the guard load value and the timeout
  // limit; never narrower than one bit so a 0/0 configuration still builds.
  function automatic int timer_width(input int guard_cycles, input int timeout_cycles);
    int m;
    m = (guard_cycles > timeout_cycles) ? guard_cycles : timeout_cycles;
    if (m < 1) begin
      return 1;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/servant_barrier_timer.sv
// servant_barrier_timer
// Loadable up/down counter shared by the barrier's guard (down-count) and
// timeout (up-count) phases; the two phases are never active together.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_load       load i_load_val (highest priority)
//   i_inc        count up
//   i_dec        count down (ignored when i_inc is set)
//   o_count      current count
module servant_barrier_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc) begin
      count_d = count_q + W'(1);
    end else if (i_dec) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/servant_grid_barrier.sv
// servant_grid_barrier
// Generation scheduler for a grid of servant cells. Collects one publish
// strobe per cell, waits GUARD_CYCLES, then issues a single-cycle broadcast
// latch pulse that every cell feeds into its GPIO in-clock. Counts
// generations, stops at an optional limit, and flags collection timeouts and
// publishes that arrive while the barrier is past collection.
// Ports:
//   i_wb_clk, i_wb_rst_n  clock, asynchronous active-low reset
//   i_enable              run while high; low aborts back to IDLE
//   i_gen_limit           generations to run, 0 = unlimited
//   i_publish             per-cell publish strobes
//   o_latch               registered broadcast latch pulse
//   o_generation          latch pulses since the last start
//   o_busy/o_done/o_fault state indications
//   o_missing             cells missing when a timeout fault occurred
//   o_overrun             sticky: publish seen in GUARD or LATCH
module servant_grid_barrier
  import servant_grid_pkg::*;
#(
  parameter int NUM_CELLS      = 9,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GEN_W          = 32
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst_n,
  input  logic                 i_enable,
  input  logic [GEN_W-1:0]     i_gen_limit,
  input  logic [NUM_CELLS-1:0] i_publish,
  output logic                 o_latch,
  output logic [GEN_W-1:0]     o_generation,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fault,
  output logic [NUM_CELLS-1:0] o_missing,
  output logic                 o_overrun
);

  localparam int TMR_W = timer_width(GUARD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] GUARD_LOAD   = TMR_W'(GUARD_CYCLES);
  // Only meaningful when the timeout is enabled.
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [STATE_W-1:0]   state_q,   state_d;
  logic [NUM_CELLS-1:0] arrived_q, arrived_d;
  logic [GEN_W-1:0]     gen_q,     gen_d;
  logic [NUM_CELLS-1:0] missing_q, missing_d;
  logic                 overrun_q, overrun_d;
  logic                 latch_q,   latch_d;

  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_load_val;
  logic                 tmr_inc;
  logic                 tmr_dec;
  logic [TMR_W-1:0]     tmr_count;

  logic [NUM_CELLS-1:0] merged;
  logic [GEN_W-1:0]     gen_inc;

  assign merged  = arrived_q | i_publish;
  assign gen_inc = gen_q + GEN_W'(1);

  servant_barrier_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (i_wb_clk),
    .rst_n      (i_wb_rst_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_inc      (tmr_inc),
    .i_dec      (tmr_dec),
    .o_count    (tmr_count)
  );

  always_comb begin
    state_d      = state_q;
    arrived_d    = arrived_q;
    gen_d        = gen_q;
    missing_d    = missing_q;
    overrun_d    = overrun_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    tmr_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d   = S_COLLECT;
          gen_d     = '0;
          arrived_d = '0;
          missing_d = '0;
          overrun_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end

      S_COLLECT: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else begin
          arrived_d = merged;
          // Completion is tested first so it wins over a coincident timeout.
          if (&merged) begin
            if (GUARD_CYCLES == 0) begin
              state_d = S_LATCH;
            end else begin
              state_d      = S_GUARD;
              tmr_load     = 1'b1;
              tmr_load_val = GUARD_LOAD;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (tmr_count == TIMEOUT_LAST)) begin
            state_d   = S_FAULT;
            missing_d = ~merged;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end

      S_GUARD: begin
        // A write landing now could collide with the latch inside the cell.
        if (|i_publish) begin
          overrun_d = 1'b1;
        end
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (tmr_count <= TMR_W'(1)) begin
          state_d = S_LATCH;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_LATCH: begin
        gen_d     = gen_inc;
        // Publishes in the latch cycle are flagged but still count toward
        // the following generation.
        arrived_d = i_publish;
        if (|i_publish) begin
          overrun_d = 1'b1;
        end
        tmr_load = 1'b1;
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if ((i_gen_limit != '0) && (gen_inc == i_gen_limit)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_DONE, S_FAULT: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Dedicated flop so the broadcast pulse is glitch-free and drops at once
  // on reset.
  assign latch_d = (state_d == S_LATCH);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q   <= S_IDLE;
      arrived_q <= '0;
      gen_q     <= '0;
      missing_q <= '0;
      overrun_q <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      gen_q     <= gen_d;
      missing_q <= missing_d;
      overrun_q <= overrun_d;
      latch_q   <= latch_d;
    end
  end

  assign o_latch      = latch_q;
  assign o_generation = gen_q;
  assign o_busy       = (state_q == S_COLLECT) || (state_q == S_GUARD) || (state_q == S_LATCH);
  assign o_done       = (state_q == S_DONE);
  assign o_fault      = (state_q == S_FAULT);
  assign o_missing    = missing_q;
  assign o_overrun    = overrun_q;

endmodule
